// File: rtl/usb_data_buffer_pkg.sv
// -----------------------------------------------------------------------------
// usb_buffer_pkg
// Shared sizing constants for the USB endpoint data buffer. The register
// block and the TX engine import the same package, so buffer geometry is
// defined in exactly one place.
// -----------------------------------------------------------------------------
package usb_buffer_pkg;

  localparam int BUFFER_DEPTH  = 64;
  localparam int BUFFER_OCC_W  = 7;
  localparam int BUFFER_DATA_W = 8;
  localparam int BUFFER_PTR_W  = $clog2(BUFFER_DEPTH);

endpackage : usb_buffer_pkg

// File: rtl/usb_data_buffer_ptr_counter.sv
// -----------------------------------------------------------------------------
// buffer_ptr_counter
// Wrapping PTR_W-bit pointer for the endpoint buffer. Counts modulo 2**PTR_W,
// so DEPTH-1 rolls over to 0 without any explicit compare.
// Ports:
//   clk      in   system clock, rising edge
//   n_rst    in   asynchronous active-low reset (count -> 0)
//   clear_i  in   synchronous clear (count -> 0), dominates enable
//   en_i     in   advance by one
//   count_o  out  current pointer value
// -----------------------------------------------------------------------------
module buffer_ptr_counter #(
  parameter int PTR_W = 6
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [PTR_W-1:0] count_o
);

  logic [PTR_W-1:0] count_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + PTR_W'(1);
    end
  end

  assign count_o = count_q;

endmodule : buffer_ptr_counter

// File: rtl/usb_data_buffer.sv
// -----------------------------------------------------------------------------
// usb_data_buffer
// 64-byte first-word-fall-through endpoint FIFO shared by the AHB-lite slave
// (pushes TX payload, pops RX payload) and the USB packet engines (push RX
// bytes, pop TX bytes).
// Ports:
//   clk, n_rst            clock / asynchronous active-low reset
//   clear, flush          synchronous flushes (AHB side / USB side)
//   store_tx_data,tx_data AHB push strobe and byte
//   get_rx_data, rx_data  AHB pop strobe and head byte
//   store_rx_packet_data, USB RX push strobe and byte
//   rx_packet_data
//   get_tx_packet_data,   USB TX pop strobe and head byte
//   tx_packet_data
//   buffer_occupancy      bytes held, 0..DEPTH
//   overrun / underrun    registered 1-cycle pulses: push dropped / pop ignored
// -----------------------------------------------------------------------------
module usb_data_buffer
  import usb_buffer_pkg::*;
#(
  parameter int DEPTH  = BUFFER_DEPTH,
  parameter int DATA_W = BUFFER_DATA_W,
  parameter int OCC_W  = BUFFER_OCC_W
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear,
  input  logic              flush,
  input  logic              store_tx_data,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              get_rx_data,
  output logic [DATA_W-1:0] rx_data,
  input  logic              store_rx_packet_data,
  input  logic [DATA_W-1:0] rx_packet_data,
  input  logic              get_tx_packet_data,
  output logic [DATA_W-1:0] tx_packet_data,
  output logic [OCC_W-1:0]  buffer_occupancy,
  output logic              overrun,
  output logic              underrun
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wptr, rptr;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              overrun_q, overrun_d;
  logic              underrun_q, underrun_d;

  logic              flush_any;
  logic              push_req, pop_req;
  logic              empty, full;
  logic              do_push, do_pop;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] head;

  assign flush_any = clear | flush;
  assign push_req  = store_rx_packet_data | store_tx_data;
  assign pop_req   = get_rx_data | get_tx_packet_data;
  assign empty     = (occ_q == '0);
  assign full      = (occ_q == OCC_FULL);

  // USB RX wins the single write port; the AHB byte is the one dropped.
  assign wdata = store_rx_packet_data ? rx_packet_data : tx_data;

  // A pop only completes when there is something to pop. A push at full is
  // accepted only if a real pop frees the slot in the same cycle.
  assign do_pop  = pop_req & ~empty & ~flush_any;
  assign do_push = push_req & (~full | pop_req) & ~flush_any;

  always_comb begin
    occ_d      = occ_q;
    overrun_d  = 1'b0;
    underrun_d = 1'b0;
    if (flush_any) begin
      occ_d = '0;
    end else begin
      occ_d      = occ_q + OCC_W'(do_push) - OCC_W'(do_pop);
      overrun_d  = (store_rx_packet_data & store_tx_data) | (push_req & ~do_push);
      underrun_d = pop_req & empty;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      occ_q      <= '0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  // Storage is deliberately not reset; the empty-gated head hides stale data.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= wdata;
    end
  end

  buffer_ptr_counter #(.PTR_W(PTR_W)) u_wptr (
    .clk     (clk),
    .n_rst   (n_rst),
    .clear_i (flush_any),
    .en_i    (do_push),
    .count_o (wptr)
  );

  buffer_ptr_counter #(.PTR_W(PTR_W)) u_rptr (
    .clk     (clk),
    .n_rst   (n_rst),
    .clear_i (flush_any),
    .en_i    (do_pop),
    .count_o (rptr)
  );

  assign head             = empty ? '0 : mem[rptr];
  assign rx_data          = head;
  assign tx_packet_data   = head;
  assign buffer_occupancy = occ_q;
  assign overrun          = overrun_q;
  assign underrun         = underrun_q;

endmodule : usb_data_buffer
